// File: rtl/uart_wb_fifo_ctrl.sv
// Wishbone register window for the UART: RX/TX circular FIFOs, sticky errors,
// interrupt generation and a TX launch FSM feeding the serialiser.
module uart_wb_fifo_ctrl #(
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RX_DEPTH  = 8,
    parameter int unsigned TX_DEPTH  = 8,
    parameter int unsigned RX_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_valid,
    input  logic [31:0]       i_wb_adr,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    output logic              o_wb_ack,
    output logic [31:0]       o_wb_dat,
    input  logic [DATA_W-1:0] i_rx,
    input  logic              i_rx_valid,
    input  logic              i_frame_err,
    output logic [DATA_W-1:0] o_tx,
    output logic              o_tx_start,
    input  logic              i_tx_busy,
    output logic              o_irq
);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int RXC = RXA + 1;
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int TXC = TXA + 1;
    localparam logic [RXC-1:0] RX_FULL = RXC'(RX_DEPTH);
    localparam logic [TXC-1:0] TX_FULL = TXC'(TX_DEPTH);
    localparam logic [RXC-1:0] RX_TH   = RXC'(RX_THRESH);

    typedef enum logic [1:0] {IDLE, START, BUSY} tx_state_e;

    logic              ack_q;
    logic [31:0]       dat_q, rdata, stat;
    logic [2:0]        ctrl_q, ctrl_d, err_q, err_d;
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [RXA-1:0]    rx_wp_q, rx_rp_q;
    logic [TXA-1:0]    tx_wp_q, tx_rp_q;
    logic [RXC-1:0]    rx_cnt_q, rx_cnt_d;
    logic [TXC-1:0]    tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0] tx_q;
    tx_state_e         state_q, state_d;
    logic              irq_q, irq_d;
    logic              acc, hit;
    logic [1:0]        off;
    logic              rd_rx, wr_tx, rd_stat, wr_ctrl;
    logic              rx_empty, rx_full, tx_empty, tx_full;
    logic              rx_flush, tx_flush, rx_ok;
    logic              rx_push, rx_pop, tx_push, tx_pop;
    logic              tx_start, tx_idle;
    logic              unused_bits;

    assign acc     = i_wb_valid & ~ack_q;
    assign hit     = i_wb_adr[31:4] == BASE_ADR[31:4];
    assign off     = i_wb_adr[3:2];
    assign rd_rx   = acc & hit & ~i_wb_we & (off == 2'd0);
    assign wr_tx   = acc & hit & i_wb_we & (off == 2'd1) & i_wb_sel[0];
    assign rd_stat = acc & hit & ~i_wb_we & (off == 2'd2);
    assign wr_ctrl = acc & hit & i_wb_we & (off == 2'd3);

    assign unused_bits = ^{i_wb_adr[1:0], i_wb_sel[3:2], i_wb_dat};

    assign rx_empty = rx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == RX_FULL;
    assign tx_empty = tx_cnt_q == '0;
    assign tx_full  = tx_cnt_q == TX_FULL;
    assign rx_flush = wr_ctrl & i_wb_sel[1] & i_wb_dat[8];
    assign tx_flush = wr_ctrl & i_wb_sel[1] & i_wb_dat[9];

    // A pop frees the slot in the same cycle, so a full FIFO can still accept
    assign rx_ok   = i_rx_valid & ~i_frame_err;
    assign rx_pop  = rd_rx & ~rx_empty;
    assign rx_push = rx_ok & (~rx_full | rx_pop);
    assign tx_push = wr_tx & (~tx_full | tx_pop);

    assign err_d  = (rd_stat ? 3'b000 : err_q)
                  | {wr_tx & ~tx_push, i_rx_valid & i_frame_err, rx_ok & ~rx_push};
    assign ctrl_d = (wr_ctrl & i_wb_sel[0]) ? i_wb_dat[2:0] : ctrl_q;

    assign stat = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), 1'b0, err_q,
                   tx_full, tx_empty, rx_full, rx_empty};

    always_comb begin
        rdata = '0;
        if (hit && !i_wb_we) begin
            case (off)
                2'd0: rdata = rx_empty ? '0 : {{(32-DATA_W){1'b0}}, rx_mem[rx_rp_q]};
                2'd2: rdata = stat;
                2'd3: rdata = {29'd0, ctrl_q};
                default: rdata = '0;
            endcase
        end
    end

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_flush)
            rx_cnt_d = '0;
        else if (rx_push && !rx_pop)
            rx_cnt_d = rx_cnt_q + RXC'(1);
        else if (!rx_push && rx_pop)
            rx_cnt_d = rx_cnt_q - RXC'(1);
    end

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_flush)
            tx_cnt_d = '0;
        else if (tx_push && !tx_pop)
            tx_cnt_d = tx_cnt_q + TXC'(1);
        else if (!tx_push && tx_pop)
            tx_cnt_d = tx_cnt_q - TXC'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!tx_empty && !i_tx_busy && !tx_flush) state_d = START;
            START:   if (i_tx_busy) state_d = BUSY;
            BUSY:    if (!i_tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start = state_q == START;
        tx_idle  = state_q == IDLE;
        tx_pop   = tx_idle && (state_d == START);
    end

    assign irq_d = (ctrl_q[0] & (rx_cnt_q >= RX_TH))
                 | (ctrl_q[1] & tx_empty & tx_idle)
                 | (ctrl_q[2] & |err_q);

    always_ff @(posedge clk) begin
        if (rx_push && !rx_flush) rx_mem[rx_wp_q] <= i_rx;
        if (tx_push && !tx_flush) tx_mem[tx_wp_q] <= i_wb_dat[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            ctrl_q   <= '0;
            err_q    <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            tx_q     <= '0;
            state_q  <= IDLE;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= acc;
            dat_q    <= acc ? rdata : '0;
            ctrl_q   <= ctrl_d;
            err_q    <= err_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            state_q  <= state_d;
            irq_q    <= irq_d;
            if (tx_pop) tx_q <= tx_mem[tx_rp_q];
            if (rx_flush) begin
                rx_wp_q <= '0;
                rx_rp_q <= '0;
            end else begin
                if (rx_push) rx_wp_q <= rx_wp_q + RXA'(1);
                if (rx_pop)  rx_rp_q <= rx_rp_q + RXA'(1);
            end
            if (tx_flush) begin
                tx_wp_q <= '0;
                tx_rp_q <= '0;
            end else begin
                if (tx_push) tx_wp_q <= tx_wp_q + TXA'(1);
                if (tx_pop)  tx_rp_q <= tx_rp_q + TXA'(1);
            end
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_dat   = dat_q;
    assign o_tx       = tx_q;
    assign o_tx_start = tx_start;
    assign o_irq      = irq_q;
endmodule

// File: tb/tb_uart_wb_fifo_ctrl.sv
// Scoreboard bench for uart_wb_fifo_ctrl: RX/TX FIFOs, STAT/CTRL, TX FSM, IRQ.
module tb_uart_wb_fifo_ctrl;
    localparam logic [31:0] B = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_wb_valid = 1'b0;
    logic [31:0] i_wb_adr = '0;
    logic        i_wb_we = 1'b0;
    logic [31:0] i_wb_dat = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        o_wb_ack;
    logic [31:0] o_wb_dat;
    logic [7:0]  i_rx = '0;
    logic        i_rx_valid = 1'b0;
    logic        i_frame_err = 1'b0;
    logic [7:0]  o_tx;
    logic        o_tx_start;
    logic        i_tx_busy = 1'b0;
    logic        o_irq;

    int n_pass = 0;
    int n_tot  = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int bcnt = 0;
    bit stall = 0;
    bit ser_off = 0;
    bit drop_chk = 0;

    uart_wb_fifo_ctrl #(.RX_THRESH(2)) dut (
        .clk(clk), .rst(rst),
        .i_wb_valid(i_wb_valid), .i_wb_adr(i_wb_adr), .i_wb_we(i_wb_we),
        .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
        .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat),
        .i_rx(i_rx), .i_rx_valid(i_rx_valid), .i_frame_err(i_frame_err),
        .o_tx(o_tx), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
        .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Serialiser model: busy for 10 cycles per launch, checks o_tx order
    always @(negedge clk) begin
        if (!ser_off) begin
            if (o_tx_start && bcnt == 0 && !stall) begin
                if (tx_q.size() == 0) check("tx_unexpected", 32'(o_tx), 32'hFFFF_FFFF);
                else check("tx_data", 32'(o_tx), 32'(tx_q.pop_front()));
                bcnt = 10;
                drop_chk = 1;
            end else begin
                if (drop_chk) begin
                    check("start_drop", 32'(o_tx_start), 0);
                    drop_chk = 0;
                end
                if (bcnt > 0) bcnt--;
            end
        end
        i_tx_busy = stall || bcnt > 0;
    end

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic rxv, input logic [7:0] rxd,
                           output logic [31:0] rd);
        bit got;
        @(negedge clk);
        i_wb_valid = 1'b1; i_wb_we = we; i_wb_adr = adr;
        i_wb_dat = dat; i_wb_sel = sel;
        i_rx = rxd; i_rx_valid = rxv; i_frame_err = 1'b0;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            i_rx_valid = 1'b0;
            if (o_wb_ack) begin
                got = 1;
                break;
            end
        end
        rd = o_wb_dat;
        i_wb_valid = 1'b0; i_wb_we = 1'b0;
        if (!got) check("ack_timeout", 0, 1);
    endtask

    task automatic rd_reg(input logic [31:0] adr, output logic [31:0] rd);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, 1'b0, 8'h00, rd);
    endtask

    task automatic wr_reg(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        wb_xfer(1'b1, adr, dat, sel, 1'b0, 8'h00, rd);
    endtask

    task automatic rx_pulse(input logic [7:0] d, input logic fe);
        @(negedge clk);
        i_rx = d; i_frame_err = fe; i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0; i_frame_err = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (tx_q.size() == 0 && bcnt == 0) break;
        end
        check("tx_drain", 32'(tx_q.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check("rst_dat", o_wb_dat, 0);
        check("rst_flags", {29'd0, o_wb_ack, o_tx_start, o_irq}, 0);
        check("rst_tx", 32'(o_tx), 0);
        rst = 1'b0;
        rd_reg(B + 32'h8, rd);  check("stat_rst", rd, 32'h5);
        rd_reg(B + 32'hC, rd);  check("ctrl_rst", rd, 0);
        rd_reg(B + 32'h10, rd); check("unmapped", rd, 0);

        for (int i = 0; i < 8; i++) begin
            d = 8'(32'hA0 + i);
            rx_q.push_back(d);
            rx_pulse(d, 1'b0);
        end
        rx_pulse(8'hFF, 1'b0);
        rd_reg(B + 32'h8, rd); check("stat_full", rd, 32'h0816);
        for (int i = 0; i < 8; i++) begin
            rd_reg(B, rd);
            check("rx_data", rd, 32'(rx_q.pop_front()));
        end
        rd_reg(B + 32'h8, rd); check("stat_clr", rd, 32'h5);
        rd_reg(B, rd);         check("rx_empty_pop", rd, 0);

        wr_reg(B + 32'hC, 32'h4, 4'h1);
        rx_pulse(8'h55, 1'b1);
        check("irq_fe_pre", 32'(o_irq), 0);
        @(negedge clk);
        check("irq_fe", 32'(o_irq), 1);
        rd_reg(B + 32'h8, rd); check("stat_fe", rd, 32'h25);
        wr_reg(B + 32'hC, 32'h0, 4'h1);

        tx_q.push_back(8'h41);
        wr_reg(B + 32'h4, 32'h41, 4'h1);
        check("txs_n1", 32'(o_tx_start), 0);
        @(negedge clk);
        check("txs_n2", 32'(o_tx_start), 1);
        check("tx_n2", 32'(o_tx), 32'h41);
        wr_reg(B + 32'h4, 32'h99, 4'hE);
        tx_q.push_back(8'h42);
        wr_reg(B + 32'h4, 32'h42, 4'h1);
        tx_q.push_back(8'h43);
        wr_reg(B + 32'h4, 32'h43, 4'h1);
        wait_drain();
        rd_reg(B + 32'h8, rd); check("stat_txdone", rd, 32'h5);

        stall = 1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            d = 8'(32'h60 + i);
            if (i < 8) tx_q.push_back(d);
            wr_reg(B + 32'h4, 32'(d), 4'h1);
        end
        rd_reg(B + 32'h8, rd); check("stat_txovf", rd, 32'h0008_0049);
        stall = 0;
        wait_drain();
        rd_reg(B + 32'h8, rd); check("stat_txovf_clr", rd, 32'h5);

        for (int i = 0; i < 3; i++) begin
            d = 8'(32'hB0 + i);
            rx_q.push_back(d);
            rx_pulse(d, 1'b0);
        end
        rx_q.push_back(8'hB3);
        wb_xfer(1'b0, B, 32'h0, 4'hF, 1'b1, 8'hB3, rd);
        check("rx_pushpop", rd, 32'(rx_q.pop_front()));
        rd_reg(B + 32'h8, rd); check("stat_cnt3", rd, 32'h0304);
        for (int i = 0; i < 3; i++) begin
            rd_reg(B, rd);
            check("rx_order", rd, 32'(rx_q.pop_front()));
        end

        rx_pulse(8'hC0, 1'b0);
        wb_xfer(1'b1, B + 32'hC, 32'h107, 4'h2, 1'b1, 8'hC1, rd);
        rd_reg(B + 32'h8, rd); check("stat_flush", rd, 32'h5);
        rd_reg(B + 32'hC, rd); check("ctrl_sel_gate", rd, 0);
        rd_reg(B, rd);         check("rx_after_flush", rd, 0);

        wr_reg(B + 32'hC, 32'h1, 4'h1);
        rd_reg(B + 32'hC, rd); check("ctrl_rd", rd, 32'h1);
        rx_pulse(8'hD0, 1'b0);
        @(negedge clk);
        check("irq_cnt1", 32'(o_irq), 0);
        rx_pulse(8'hD1, 1'b0);
        check("irq_cnt2_pre", 32'(o_irq), 0);
        @(negedge clk);
        check("irq_cnt2", 32'(o_irq), 1);
        rd_reg(B, rd);
        check("irq_pop_data", rd, 32'hD0);
        check("irq_pop_hold", 32'(o_irq), 1);
        @(negedge clk);
        check("irq_pop_fall", 32'(o_irq), 0);
        rd_reg(B, rd); check("irq_last", rd, 32'hD1);
        wr_reg(B + 32'hC, 32'h0, 4'h1);

        ser_off = 1;
        wr_reg(B + 32'h4, 32'h5A, 4'h1);
        @(negedge clk);
        check("mid_start", 32'(o_tx_start), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_start", 32'(o_tx_start), 0);
        check("mid_rst_tx", 32'(o_tx), 0);
        @(negedge clk);
        rst = 1'b0;
        ser_off = 0;
        rd_reg(B + 32'h8, rd); check("stat_mid_rst", rd, 32'h5);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
